column_merge: RTL and testbench

//  Back end of the 3x3 median filter. Consumes the stream of per-column sorted triples
//  (L >= M >= S) produced by the column sort stage and keeps a sliding window of the last
//  3 columns. Emits the 3x3 median as median(min(L), median(M), max(S)).

---
 rtl/column_merge_if.sv | 33 +++
 rtl/column_merge.sv | 138 +++++++++++++
 tb/tb_column_merge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/column_merge_if.sv
// Column stream in / median stream out between the column sort stage, this merge stage and
// the pixel writer.
interface column_merge_if #(
  parameter int unsigned DATA_W = 8
);
  logic              col_valid;
  logic              line_start;
  logic [DATA_W-1:0] L_in;
  logic [DATA_W-1:0] M_in;
  logic [DATA_W-1:0] S_in;
  logic [DATA_W-1:0] med_out;
  logic              med_valid;

  modport master (
    output col_valid,
    output line_start,
    output L_in,
    output M_in,
    output S_in,
    input  med_out,
    input  med_valid
  );

  modport slave (
    input  col_valid,
    input  line_start,
    input  L_in,
    input  M_in,
    input  S_in,
    output med_out,
    output med_valid
  );
endinterface

// File: rtl/column_merge.sv
// 3x3 median back end: sliding window over the last three sorted columns, then
// median(min(L), median(M), max(S)) in a three-register pipeline.
module column_merge #(
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  column_merge_if.slave bus
);

  typedef logic [DATA_W-1:0] pix_t;

  // Fill state counts columns already held for the current row: 0, 1, or 2-and-more.
  typedef enum logic [1:0] {
    StFill0 = 2'd0,
    StFill1 = 2'd1,
    StRun   = 2'd2
  } fill_state_e;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  fill_state_e state_q, state_d;

  pix_t c0_l_q, c0_m_q, c0_s_q;
  pix_t c1_l_q, c1_m_q, c1_s_q;
  pix_t c2_l_q, c2_m_q, c2_s_q;
  logic w_valid_q, w_valid_d;

  pix_t p_l_q, p_m_q, p_s_q;
  logic v1_q;

  pix_t med_q;
  logic med_valid_q;

  // A column completes a window only when two earlier columns of the same row are held;
  // a line_start column always begins a new row and never completes one.
  always_comb begin
    state_d   = state_q;
    w_valid_d = 1'b0;
    if (bus.col_valid) begin
      if (bus.line_start) begin
        state_d = StFill1;
      end else begin
        unique case (state_q)
          StFill0: state_d = StFill1;
          StFill1: state_d = StRun;
          StRun:   state_d = StRun;
          default: state_d = StFill0;
        endcase
        w_valid_d = (state_q == StRun);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_valid_q <= w_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_l_q <= '0;
      c0_m_q <= '0;
      c0_s_q <= '0;
      c1_l_q <= '0;
      c1_m_q <= '0;
      c1_s_q <= '0;
      c2_l_q <= '0;
      c2_m_q <= '0;
      c2_s_q <= '0;
    end else if (bus.col_valid) begin
      c2_l_q <= c1_l_q;
      c2_m_q <= c1_m_q;
      c2_s_q <= c1_s_q;
      c1_l_q <= c0_l_q;
      c1_m_q <= c0_m_q;
      c1_s_q <= c0_s_q;
      c0_l_q <= bus.L_in;
      c0_m_q <= bus.M_in;
      c0_s_q <= bus.S_in;
    end
  end

  // Stage 1 runs every cycle; v1 alone decides whether its result is meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_l_q <= '0;
      p_m_q <= '0;
      p_s_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      p_l_q <= min3(c0_l_q, c1_l_q, c2_l_q);
      p_m_q <= med3(c0_m_q, c1_m_q, c2_m_q);
      p_s_q <= max3(c0_s_q, c1_s_q, c2_s_q);
      v1_q  <= w_valid_q;
    end
  end

  // Output only updates on a valid window so med_out holds across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      med_q       <= '0;
      med_valid_q <= 1'b0;
    end else begin
      med_valid_q <= v1_q;
      if (v1_q) begin
        med_q <= med3(p_l_q, p_m_q, p_s_q);
      end
    end
  end

  assign bus.med_out   = med_q;
  assign bus.med_valid = med_valid_q;

endmodule

// File: tb/tb_column_merge.sv
// Randomised plus directed bench for column_merge: a row-aware reference model feeds a
// scoreboard queue of (due cycle, value) that an independent monitor drains.
module tb_column_merge;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    int l;
    int m;
    int s;
  } col_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  logic [7:0] last_out;

  exp_t q[$];
  col_t row[$];

  column_merge_if #(.DATA_W(8)) bus ();

  column_merge #(.DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input int which, input int a, input int b, input int c);
    int t[$];
    t = {a, b, c};
    t.sort();
    return t[which];
  endfunction

  // Reference: the 3x3 median of a window is median(min of L, median of M, max of S).
  function automatic logic [7:0] window_median();
    int n;
    int lo_l;
    int mid_m;
    int hi_s;
    n     = row.size();
    lo_l  = pick(0, row[n-1].l, row[n-2].l, row[n-3].l);
    mid_m = pick(1, row[n-1].m, row[n-2].m, row[n-3].m);
    hi_s  = pick(2, row[n-1].s, row[n-2].s, row[n-3].s);
    return 8'(pick(1, lo_l, mid_m, hi_s));
  endfunction

  task automatic send(input bit v, input bit ls, input int l, input int m, input int s);
    exp_t e;
    col_t c;
    @(posedge clk);
    #1;
    bus.col_valid  = v;
    bus.line_start = ls;
    bus.L_in       = 8'(l);
    bus.M_in       = 8'(m);
    bus.S_in       = 8'(s);
    if (v) begin
      if (ls) row.delete();
      c.l = l;
      c.m = m;
      c.s = s;
      row.push_back(c);
      if (row.size() > 3) void'(row.pop_front());
      if (row.size() == 3) begin
        e.due = cyc + 3;
        e.val = window_median();
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      send(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.col_valid  = 1'b0;
    bus.line_start = 1'b0;
    q.delete();
    row.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rnd_pix();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   ok;
    #2;
    ok = 1'b1;
    total++;
    if (!rst_n) begin
      if (bus.med_valid !== 1'b0 || bus.med_out !== 8'd0) begin
        ok = 1'b0;
        $display("FAIL reset_out cyc=%0d got valid=%b out=%0d want valid=0 out=0", cyc,
                 bus.med_valid, bus.med_out);
      end
      last_out = 8'd0;
    end else if (bus.med_valid === 1'b1) begin
      if (q.size() == 0) begin
        ok = 1'b0;
        $display("FAIL spurious_pulse cyc=%0d got out=%0d want no pulse", cyc, bus.med_out);
      end else begin
        e = q.pop_front();
        if (bus.med_out !== e.val || cyc != e.due) begin
          ok = 1'b0;
          $display("FAIL median cyc=%0d got out=%0d want out=%0d at cyc=%0d", cyc,
                   bus.med_out, e.val, e.due);
        end
      end
      last_out = bus.med_out;
    end else begin
      if (bus.med_valid !== 1'b0 || bus.med_out !== last_out) begin
        ok = 1'b0;
        $display("FAIL hold cyc=%0d got valid=%b out=%0d want valid=0 out=%0d", cyc,
                 bus.med_valid, bus.med_out, last_out);
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        ok = 1'b0;
        $display("FAIL missing_pulse cyc=%0d got none want out=%0d at cyc=%0d", cyc,
                 q[0].val, q[0].due);
        void'(q.pop_front());
      end
    end
    if (!ok) bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total          = 0;
    bad            = 0;
    last_out       = 8'd0;
    rst_n          = 1'b0;
    bus.col_valid  = 1'b0;
    bus.line_start = 1'b0;
    bus.L_in       = 8'd0;
    bus.M_in       = 8'd0;
    bus.S_in       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic window, back-to-back follow-on, then the same pair separated by gaps.
    send(1, 0, 15, 9, 0);
    send(1, 0, 12, 10, 8);
    send(1, 0, 9, 7, 7);
    send(1, 0, 20, 20, 20);
    idle(6);
    send(1, 1, 15, 9, 0);
    idle(4);
    send(1, 0, 12, 10, 8);
    idle(4);
    send(1, 0, 9, 7, 7);
    idle(4);
    send(1, 0, 20, 20, 20);
    idle(2);

    // New row while results are in flight.
    send(1, 0, 30, 2, 1);
    send(1, 1, 5, 5, 5);
    send(1, 0, 5, 5, 5);
    send(1, 0, 6, 6, 6);
    idle(5);

    // Reset with two results in flight, then refill.
    send(1, 0, 40, 30, 20);
    send(1, 0, 50, 45, 44);
    pulse_reset();
    send(1, 0, 1, 1, 1);
    send(1, 0, 2, 2, 2);
    idle(4);

    // Extremes and ties.
    send(1, 1, 255, 255, 255);
    send(1, 0, 255, 255, 255);
    send(1, 0, 255, 255, 255);
    send(1, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0);
    idle(5);

    for (int i = 0; i < 600; i++) begin
      int a;
      int b;
      int c;
      a = rnd_pix();
      b = rnd_pix();
      c = rnd_pix();
      if ($urandom_range(0, 99) < 70) begin
        send(1, 1'($urandom_range(0, 99) < 8), pick(2, a, b, c), pick(1, a, b, c),
             pick(0, a, b, c));
      end else begin
        send(0, 1'($urandom_range(0, 1)), a, b, c);
      end
      if (i == 300) pulse_reset();
    end
    idle(8);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
